// File: rtl/sevenseg_sequence_controller.sv
// Latches a binary value, converts it to BCD with a serial double-dabble engine,
// then steps the digits MSD-first onto one 7-segment output, with timed or triggered advance.
module sevenseg_sequence_controller #(
    parameter int VALUE_WIDTH  = 8,
    parameter int NUM_DIGITS   = 3,
    parameter int DWELL_CYCLES = 1000,
    parameter int GAP_CYCLES   = 100,
    parameter int LZ_BLANK     = 1,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [VALUE_WIDTH-1:0] value,
    input  logic                   auto_mode,
    input  logic                   trigger,
    output logic [6:0]             seg,
    output logic [IDX_W-1:0]       digit_idx,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam int BCD_W    = 4 * NUM_DIGITS;
    localparam int TMR_MAX  = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);
    localparam int BIT_W    = $clog2(VALUE_WIDTH + 1);
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [2:0] {IDLE, CONVERT, SHOW, GAP, FINISH} state_t;

    state_t                 state;
    logic [VALUE_WIDTH-1:0] bin_sr;
    logic [BCD_W-1:0]       bcd;
    logic [BIT_W-1:0]       bit_cnt;
    logic [TMR_W-1:0]       timer;
    logic                   auto_lat;

    logic [BCD_W-1:0]       adj;
    logic [BCD_W-1:0]       bcd_next;
    logic                   carry_out;
    logic                   ovf_next;
    logic [IDX_W-1:0]       first_idx;
    logic                   is_last;
    logic                   advance;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h3F;
            4'd1:    seg_code = 7'h06;
            4'd2:    seg_code = 7'h5B;
            4'd3:    seg_code = 7'h4F;
            4'd4:    seg_code = 7'h66;
            4'd5:    seg_code = 7'h6D;
            4'd6:    seg_code = 7'h7D;
            4'd7:    seg_code = 7'h07;
            4'd8:    seg_code = 7'h7F;
            4'd9:    seg_code = 7'h6F;
            default: seg_code = 7'h00;
        endcase
    endfunction

    // Index 0 is the most significant nibble, i.e. the top of the BCD register.
    function automatic logic [6:0] show_code(input logic [BCD_W-1:0] b,
                                             input logic             ovf,
                                             input logic [IDX_W-1:0] idx);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) d = b[4*(NUM_DIGITS-1-i) +: 4];
        end
        return ovf ? 7'h40 : seg_code(d);
    endfunction

    // One shift-add-3 step; whatever falls off the top nibble means the value needs more digits.
    always_comb begin
        adj = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
        {carry_out, bcd_next} = {adj, bin_sr[VALUE_WIDTH-1]};
        ovf_next = overflow | carry_out;
    end

    always_comb begin
        first_idx = IDX_W'(NUM_DIGITS - 1);
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (bcd_next[4*(NUM_DIGITS-1-i) +: 4] != 4'd0) first_idx = IDX_W'(i);
        end
        if (LZ_BLANK == 0 || ovf_next) first_idx = '0;
    end

    always_comb begin
        is_last = (digit_idx == IDX_W'(NUM_DIGITS - 1));
        advance = 1'b0;
        if (state == SHOW && GAP_CYCLES == 0)
            advance = auto_lat ? (timer == '0) : trigger;
        else if (state == GAP)
            advance = (timer == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            seg       <= 7'h00;
            digit_idx <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            bin_sr    <= '0;
            bcd       <= '0;
            bit_cnt   <= '0;
            timer     <= '0;
            auto_lat  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr    <= value;
                        bcd       <= '0;
                        overflow  <= 1'b0;
                        auto_lat  <= auto_mode;
                        bit_cnt   <= BIT_W'(VALUE_WIDTH - 1);
                        busy      <= 1'b1;
                        state     <= CONVERT;
                    end
                end
                CONVERT: begin
                    bin_sr   <= bin_sr << 1;
                    bcd      <= bcd_next;
                    overflow <= ovf_next;
                    if (bit_cnt == '0) begin
                        digit_idx <= first_idx;
                        seg       <= show_code(bcd_next, ovf_next, first_idx);
                        timer     <= TMR_W'(DWELL_CYCLES - 1);
                        state     <= SHOW;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                SHOW: begin
                    if (auto_lat ? (timer == '0) : trigger) begin
                        if (GAP_CYCLES > 0) begin
                            seg   <= 7'h00;
                            timer <= TMR_W'(GAP_LOAD);
                            state <= GAP;
                        end
                    end else if (auto_lat) begin
                        timer <= timer - 1'b1;
                    end
                end
                GAP: begin
                    if (timer != '0) timer <= timer - 1'b1;
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Shared exit from SHOW (no gap) or GAP: next digit, or wrap up.
            if (advance) begin
                if (is_last) begin
                    seg   <= 7'h00;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= FINISH;
                end else begin
                    digit_idx <= digit_idx + 1'b1;
                    seg       <= show_code(bcd, overflow, digit_idx + 1'b1);
                    timer     <= TMR_W'(DWELL_CYCLES - 1);
                    state     <= SHOW;
                end
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_sequence_controller.sv
// Bench for sevenseg_sequence_controller: four parameter sets share one stimulus path,
// and a decimal model fills a scoreboard of expected digits for each sequence.
module tb_sevenseg_sequence_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] value;
    logic       auto_mode;
    logic       trigger;
    int         sel;

    int tests    = 0;
    int failures = 0;

    typedef struct {
        logic [6:0] seg;
        int         idx;
        int         dur;
    } exp_t;
    exp_t sb[$];

    int cfg_vw[4] = '{8, 8, 8, 10};
    int cfg_nd[4] = '{3, 3, 2, 4};
    int cfg_dw[4] = '{4, 4, 4, 3};
    int cfg_gp[4] = '{2, 2, 2, 0};
    int cfg_lz[4] = '{1, 0, 1, 1};

    logic [6:0] seg_main, seg_nolz, seg_ovf, seg_wide;
    logic [1:0] idx_main, idx_nolz, idx_wide;
    logic       idx_ovf;
    logic       busy_main, busy_nolz, busy_ovf, busy_wide;
    logic       done_main, done_nolz, done_ovf, done_wide;
    logic       ovf_main, ovf_nolz, ovf_ovf, ovf_wide;

    logic [6:0] obs_seg;
    logic [1:0] obs_idx;
    logic       obs_busy, obs_done, obs_ovf;

    always #5 clk = ~clk;

    sevenseg_sequence_controller #(.VALUE_WIDTH(8), .NUM_DIGITS(3), .DWELL_CYCLES(4),
                                   .GAP_CYCLES(2), .LZ_BLANK(1)) u_main (
        .clk(clk), .rst(rst), .start(start && sel == 0), .value(value[7:0]),
        .auto_mode(auto_mode), .trigger(trigger), .seg(seg_main), .digit_idx(idx_main),
        .busy(busy_main), .done(done_main), .overflow(ovf_main));

    sevenseg_sequence_controller #(.VALUE_WIDTH(8), .NUM_DIGITS(3), .DWELL_CYCLES(4),
                                   .GAP_CYCLES(2), .LZ_BLANK(0)) u_nolz (
        .clk(clk), .rst(rst), .start(start && sel == 1), .value(value[7:0]),
        .auto_mode(auto_mode), .trigger(trigger), .seg(seg_nolz), .digit_idx(idx_nolz),
        .busy(busy_nolz), .done(done_nolz), .overflow(ovf_nolz));

    sevenseg_sequence_controller #(.VALUE_WIDTH(8), .NUM_DIGITS(2), .DWELL_CYCLES(4),
                                   .GAP_CYCLES(2), .LZ_BLANK(1)) u_ovf (
        .clk(clk), .rst(rst), .start(start && sel == 2), .value(value[7:0]),
        .auto_mode(auto_mode), .trigger(trigger), .seg(seg_ovf), .digit_idx(idx_ovf),
        .busy(busy_ovf), .done(done_ovf), .overflow(ovf_ovf));

    sevenseg_sequence_controller #(.VALUE_WIDTH(10), .NUM_DIGITS(4), .DWELL_CYCLES(3),
                                   .GAP_CYCLES(0), .LZ_BLANK(1)) u_wide (
        .clk(clk), .rst(rst), .start(start && sel == 3), .value(value),
        .auto_mode(auto_mode), .trigger(trigger), .seg(seg_wide), .digit_idx(idx_wide),
        .busy(busy_wide), .done(done_wide), .overflow(ovf_wide));

    always_comb begin
        obs_seg  = 7'h00;
        obs_idx  = 2'd0;
        obs_busy = 1'b0;
        obs_done = 1'b0;
        obs_ovf  = 1'b0;
        case (sel)
            0: begin obs_seg = seg_main; obs_idx = idx_main; obs_busy = busy_main; obs_done = done_main; obs_ovf = ovf_main; end
            1: begin obs_seg = seg_nolz; obs_idx = idx_nolz; obs_busy = busy_nolz; obs_done = done_nolz; obs_ovf = ovf_nolz; end
            2: begin obs_seg = seg_ovf; obs_idx = {1'b0, idx_ovf}; obs_busy = busy_ovf; obs_done = done_ovf; obs_ovf = ovf_ovf; end
            default: begin obs_seg = seg_wide; obs_idx = idx_wide; obs_busy = busy_wide; obs_done = done_wide; obs_ovf = ovf_wide; end
        endcase
    end

    function automatic logic [6:0] segOf(input int d);
        case (d)
            0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
            5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; default: return 7'h6F;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Decimal model fills the scoreboard, then the start pulse is driven; returns in the first busy cycle.
    task automatic applyStimulus(input int s, input int val, input bit auto_m,
                                 output int exp_total, output bit exp_ovf);
        int nd, pw, v, first, shown;
        int dig[4];
        nd = cfg_nd[s];
        pw = 1;
        for (int i = 0; i < nd; i++) pw = pw * 10;
        exp_ovf = (val >= pw);
        v = val;
        for (int i = nd - 1; i >= 0; i--) begin
            dig[i] = v % 10;
            v = v / 10;
        end
        first = 0;
        if (cfg_lz[s] != 0 && !exp_ovf)
            while (first < nd - 1 && dig[first] == 0) first++;
        shown = 0;
        for (int i = first; i < nd; i++) begin
            sb.push_back('{exp_ovf ? 7'h40 : segOf(dig[i]), i, auto_m ? cfg_dw[s] : 0});
            shown++;
        end
        exp_total = cfg_vw[s] + shown * (cfg_dw[s] + cfg_gp[s]) + 1;
        @(negedge clk);
        sel = s; value = 10'(val); auto_mode = auto_m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic closeRun(input logic [6:0] pseg, input int pidx, input int run);
        exp_t e;
        if (sb.size() == 0) begin
            checkOutput("unexpected_digit", 32'(pseg), 32'h0);
        end else begin
            e = sb.pop_front();
            checkOutput("digit_seg", 32'(pseg), 32'(e.seg));
            checkOutput("digit_idx", pidx, e.idx);
            if (e.dur > 0) checkOutput("digit_dwell", run, e.dur);
        end
    endtask

    // Watches one sequence to its done pulse, popping the scoreboard at the end of each shown digit.
    task automatic collect(input int exp_total, input bit exp_ovf, input int poke_at, input int poke_val);
        logic [6:0] pseg;
        int  pidx, run;
        bit  active, seen_done;
        active = 0; seen_done = 0; run = 0; pseg = 7'h00; pidx = 0;
        for (int c = 1; c <= 300 && !seen_done; c++) begin
            if (c > 1) @(negedge clk);
            start = (c == poke_at);
            if (c == poke_at) value = 10'(poke_val);
            if (c == 1) checkOutput("busy_after_start", 32'(obs_busy), 32'h1);
            if (active && (obs_seg == 7'h00 || obs_seg != pseg || int'(obs_idx) != pidx)) begin
                closeRun(pseg, pidx, run);
                active = 0;
            end
            if (obs_seg != 7'h00) begin
                if (!active) begin
                    active = 1; pseg = obs_seg; pidx = int'(obs_idx); run = 0;
                end
                run++;
            end
            if (obs_done) begin
                seen_done = 1;
                checkOutput("total_cycles", c, exp_total);
                checkOutput("ovf_at_done", 32'(obs_ovf), 32'(exp_ovf));
                checkOutput("busy_at_done", 32'(obs_busy), 32'h0);
            end
        end
        start = 1'b0;
        checkOutput("done_seen", 32'(seen_done), 32'h1);
        checkOutput("digits_left", sb.size(), 0);
        sb.delete();
    endtask

    task automatic runAuto(input int s, input int val, input int poke_at, input int poke_val);
        int  tot;
        bit  ovf;
        applyStimulus(s, val, 1'b1, tot, ovf);
        collect(tot, ovf, poke_at, poke_val);
    endtask

    task automatic checkIdle(input string tag);
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            checkOutput({tag, "_seg"}, 32'(obs_seg), 32'h0);
            checkOutput({tag, "_idx"}, 32'(obs_idx), 32'h0);
            checkOutput({tag, "_busy"}, 32'(obs_busy), 32'h0);
            checkOutput({tag, "_done"}, 32'(obs_done), 32'h0);
            checkOutput({tag, "_ovf"}, 32'(obs_ovf), 32'h0);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t e;
        int   tot;
        bit   ovf;
        rst = 1'b1; start = 1'b0; value = '0; auto_mode = 1'b1; trigger = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkIdle("reset");

        runAuto(0, 123, 0, 0);
        runAuto(0, 7, 0, 0);
        runAuto(0, 200, 0, 0);
        runAuto(0, 0, 0, 0);
        runAuto(0, 255, 0, 0);
        runAuto(0, 123, 12, 99);
        runAuto(1, 7, 0, 0);
        runAuto(2, 150, 0, 0);
        runAuto(2, 99, 0, 0);
        runAuto(2, 100, 0, 0);
        runAuto(3, 1023, 0, 0);
        runAuto(3, 5, 0, 0);

        // Manual advance: the shown digit must hold until a trigger, and a trigger in the gap is dropped.
        applyStimulus(0, 45, 1'b0, tot, ovf);
        repeat (58) @(negedge clk);
        e = sb.pop_front();
        checkOutput("man_hold_seg", 32'(obs_seg), 32'(e.seg));
        checkOutput("man_hold_idx", 32'(obs_idx), e.idx);
        checkOutput("man_hold_busy", 32'(obs_busy), 32'h1);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        checkOutput("man_gap_seg", 32'(obs_seg), 32'h0);
        checkOutput("man_gap_idx", 32'(obs_idx), 32'h1);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        checkOutput("man_gap2_seg", 32'(obs_seg), 32'h0);
        @(negedge clk);
        e = sb.pop_front();
        checkOutput("man_second_seg", 32'(obs_seg), 32'(e.seg));
        checkOutput("man_second_idx", 32'(obs_idx), e.idx);
        repeat (5) @(negedge clk);
        checkOutput("man_second_hold", 32'(obs_seg), 32'(e.seg));
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("man_done", 32'(obs_done), 32'h1);
        checkOutput("man_busy_end", 32'(obs_busy), 32'h0);
        @(negedge clk);
        checkOutput("man_done_pulse", 32'(obs_done), 32'h0);
        checkOutput("man_sb_empty", sb.size(), 0);
        sb.delete();

        // Reset while an overflowed sequence is on display.
        applyStimulus(2, 150, 1'b1, tot, ovf);
        repeat (9) @(negedge clk);
        checkOutput("pre_rst_seg", 32'(obs_seg), 32'h40);
        checkOutput("pre_rst_ovf", 32'(obs_ovf), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        checkIdle("midrst");
        runAuto(0, 45, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/sevenseg_sequence_controller.md
Name: sevenseg_sequence_controller

Overview:
Parametrised successor to the fixed 3-digit display sequencer. It latches an unsigned value on `start` and converts it to BCD with a sequential double-dabble engine. It then presents the digits one at a time, most significant first, on a single 7-segment output. Advance is either by a dwell timer (auto mode) or by `trigger` pulses (manual mode), with a blank gap between digits, optional leading-zero suppression and overflow indication. It sits between the game logic and the shared 7-segment pins.

Parameters:
VALUE_WIDTH, 8, width of `value` in bits (>=1).
NUM_DIGITS, 3, number of decimal digits displayed (>=1).
DWELL_CYCLES, 1000, cycles each digit is shown in auto mode (>=1).
GAP_CYCLES, 100, blank cycles after each shown digit; 0 means no gap.
LZ_BLANK, 1, 1 = skip leading zero digits; 0 = show them.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request; latches `value` and `auto_mode`
value  input  VALUE_WIDTH  unsigned number to display
auto_mode  input  1  1 = dwell-timer advance; 0 = advance on `trigger`
trigger  input  1  single-cycle advance pulse (manual mode only)
seg  output  7  segments {g,f,e,d,c,b,a}, active-high, registered
digit_idx  output  IDX_W  position of the shown digit, 0 = most significant; IDX_W = max(1, clog2(NUM_DIGITS))
busy  output  1  high from the cycle after accepted `start` until return to IDLE
done  output  1  one-cycle pulse when the sequence finishes
overflow  output  1  value >= 10^NUM_DIGITS for the current sequence; held until the next accepted `start` or `rst`

Behaviour:
- Reset, and the IDLE state: seg=7'h00, digit_idx=0, busy=0, done=0, overflow=0. Reset at any point aborts the sequence and returns to IDLE on the next edge.
- Segment codes: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F; blank 00; dash 40.
- States and transitions:
  - IDLE: `start`=1 latches `value` and `auto_mode` and goes to CONVERT. `trigger` is ignored.
  - CONVERT: shift-add-3 engine, exactly VALUE_WIDTH cycles, seg blank. BCD register is 4*NUM_DIGITS bits wide; bits shifted out of the top set the overflow flag. Overflow is also set if the final BCD count exceeds NUM_DIGITS digits. Then go to SHOW with the first displayed index: the first nonzero digit if LZ_BLANK=1, else index 0.
  - Value 0 with LZ_BLANK=1: only the last digit (index NUM_DIGITS-1) is shown, as "0". The least-significant digit is never suppressed.
  - Overflow: every index 0..NUM_DIGITS-1 is shown as a dash. Leading-zero suppression does not apply.
  - SHOW: seg = code of the current digit and digit_idx = its index. Auto mode: stay exactly DWELL_CYCLES cycles. Manual mode: stay until `trigger`=1, then leave on the next edge. Next state is GAP if GAP_CYCLES>0, else SHOW of the next index, or FINISH after the last index. Zeros after the first shown digit are always displayed.
  - GAP: seg blank, digit_idx unchanged, exactly GAP_CYCLES cycles. `trigger` is ignored. Then SHOW of the next index, or FINISH after the last index.
  - FINISH: one cycle; done=1, busy=0, seg blank; then IDLE.
- Ignored inputs: `start` while busy is ignored; the latched value and mode stay unchanged. `trigger` has no effect in auto mode.
- Latency: with `start` sampled at edge k, busy=1 from k+1. The first digit appears on seg at edge k+1+VALUE_WIDTH.
- Total auto-mode duration: VALUE_WIDTH + D*(DWELL_CYCLES+GAP_CYCLES) + 1 cycles, where D = number of shown digits.
- Counters: the dwell/gap counter is sized for max(DWELL_CYCLES, GAP_CYCLES). It reloads on every state entry and never wraps.

Test Plan:
- Defaults with DWELL=4, GAP=2, auto: value=123 -> seg 06 (idx0, 4 cycles), 00 (2 cycles), 5B (idx1), 00, 4F (idx2), 00, then done pulse. Check total = 8+3*6+1 cycles.
- Leading zeros, LZ_BLANK=1: value=7 -> only 07 shown at idx2. Value=200 -> 5B, 3F, 3F. Value=0 -> single 3F at idx2. With LZ_BLANK=0, value=7 -> 3F, 3F, 07.
- Overflow: NUM_DIGITS=2, value=150 -> overflow=1, seg 40 at idx0 and idx1, then done.
- Manual mode: value=45 with no trigger for 50 cycles -> seg holds 66 at idx1. Trigger -> gap, then 6D at idx2. Second trigger -> done. A trigger during GAP has no effect.
- Ignored start: `start` with value=99 during a busy sequence for 123 -> digits of 123 unchanged.
- Reset mid-operation: `rst` during SHOW -> next cycle seg=00, busy=0, overflow=0. A fresh `start` then works normally.
- Wide configuration: VALUE_WIDTH=10, NUM_DIGITS=4, value=1023 -> 06, 3F, 5B, 4F.
